dct16_stage4: RTL and testbench

- Streaming butterfly stage placed directly downstream of the 1/2 safe-scaling stage (stage 3) in the 16-point DCT pipeline.
- Collects each 16-sample serial frame into a ping-pong buffer, then streams out 16 butterfly results: eight half-sums followed by eight half-differences of mirrored sample pairs.
- Sustains one sample per cycle in and out, with no bubbles between back-to-back frames.

---
 rtl/dct16_stage4.sv | 136 +++++++++++++
 tb/tb_dct16_stage4.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dct16_stage4.sv
// Stage-4 butterfly of the 16-point DCT: ping-pong frame capture, then 8 half-sums and 8 half-differences.
// Optional macro DCT16_STAGE4_ROUND_EN selects round-half-up instead of truncation of the final halving.
module dct16_stage4 #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_sample,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_sample,
  output logic [3:0]            out_index,
  output logic                  out_last
);

  if (FRAME_LEN != 16) begin : g_len_check
    $error("dct16_stage4 supports FRAME_LEN = 16 only");
  end

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [0:31];
  logic [3:0]            wr_cnt, rd_cnt, wr_idx;
  logic                  wr_bank, rd_bank;
  logic [1:0]            full;
  logic                  frame_done, emit, drained;

  // An in_sof sample always lands at index 0 of the current write bank.
  assign wr_idx     = in_sof ? 4'd0 : wr_cnt;
  assign frame_done = in_valid && !in_sof && (wr_cnt == 4'd15);

  always_ff @(posedge clk) begin
    if (in_valid) mem[{wr_bank, wr_idx}] <= in_sample;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= 4'd0;
      wr_bank <= 1'b0;
    end else if (in_valid) begin
      wr_cnt <= in_sof ? 4'd1 : wr_cnt + 4'd1;
      if (frame_done) wr_bank <= ~wr_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 2'b00;
    end else begin
      if (drained)    full[rd_bank] <= 1'b0;
      if (frame_done) full[wr_bank] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // k=0 is emitted on the IDLE->DRAIN edge so the first result follows the completion edge directly.
  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    drained = 1'b0;
    case (state_q)
      IDLE: begin
        if (full[rd_bank]) begin
          emit    = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        emit = 1'b1;
        if (rd_cnt == 4'd15) begin
          drained = 1'b1;
          state_d = full[~rd_bank] ? DRAIN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt  <= 4'd0;
      rd_bank <= 1'b0;
    end else if (emit) begin
      rd_cnt <= rd_cnt + 4'd1;
      if (drained) rd_bank <= ~rd_bank;
    end
  end

  logic [DATA_WIDTH-1:0] xa, xb, y;
  logic signed [DATA_WIDTH:0] a, b, s;

  // Mirrored pair: index j and 15-j, with j taken from the low three bits of k.
  always_comb begin
    xa = mem[{rd_bank, 1'b0, rd_cnt[2:0]}];
    xb = mem[{rd_bank, 1'b1, ~rd_cnt[2:0]}];
    a  = {xa[DATA_WIDTH-1], xa};
    b  = {xb[DATA_WIDTH-1], xb};
    s  = rd_cnt[3] ? a - b : a + b;
  end

`ifdef DCT16_STAGE4_ROUND_EN
  logic signed [DATA_WIDTH+1:0] sr;
  always_comb begin
    sr = {s[DATA_WIDTH], s} + (DATA_WIDTH+2)'(1);
    y  = DATA_WIDTH'(sr >>> 1);
  end
`else
  always_comb begin
    y = DATA_WIDTH'(s >>> 1);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_sample <= '0;
      out_index  <= 4'd0;
      out_last   <= 1'b0;
    end else begin
      out_valid <= emit;
      if (emit) begin
        out_sample <= y;
        out_index  <= rd_cnt;
        out_last   <= (rd_cnt == 4'd15);
      end
    end
  end

endmodule

// File: tb/tb_dct16_stage4.sv
// Directed bench for dct16_stage4: reset, ramp, extremes, back-to-back, sparse input, resync, reset mid-drain.
module tb_dct16_stage4;
`ifdef DCT16_STAGE4_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [15:0] in_sample = 16'h0000;
  logic        out_valid;
  logic [15:0] out_sample;
  logic [3:0]  out_index;
  logic        out_last;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cyc = 0;

  logic [15:0] din_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_s[$];
  logic [3:0]  got_i[$];
  logic        got_l[$];
  int          got_c[$];

  dct16_stage4 #(.DATA_WIDTH(16), .FRAME_LEN(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_sample(in_sample),
    .out_valid(out_valid), .out_sample(out_sample), .out_index(out_index), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      got_s.push_back(out_sample);
      got_i.push_back(out_index);
      got_l.push_back(out_last);
      got_c.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_q;
    din_q.delete(); exp_q.delete();
    got_s.delete(); got_i.delete(); got_l.delete(); got_c.delete();
  endtask

  // kind 0: x=i, 1: all 32767, 2: x0=32767 x15=-32768, 3: x=100+i
  task automatic frame(input int kind);
    for (int i = 0; i < 16; i++) begin
      case (kind)
        0:       din_q.push_back(16'(i));
        1:       din_q.push_back(16'd32767);
        2:       din_q.push_back(i == 0 ? 16'h7fff : (i == 15 ? 16'h8000 : 16'h0000));
        default: din_q.push_back(16'(100 + i));
      endcase
    end
    for (int k = 0; k < 16; k++) begin
      case (kind)
        1: exp_q.push_back(k < 8 ? 16'd32767 : 16'd0);
        // y8: (32767+32768)>>>1 = 32767; rounded, 65536>>>1 = 32768 wraps to 16'h8000
        2: exp_q.push_back(k == 0 ? 16'(RND - 1) :
                           (k == 8 ? (RND != 0 ? 16'h8000 : 16'h7fff) : 16'h0000));
        default: exp_q.push_back(k < 8 ? 16'((kind == 0 ? 7 : 107) + RND) : 16'(k - 16 + RND));
      endcase
    end
  endtask

  task automatic run(input int gap);
    for (int i = 0; i < din_q.size(); i++) begin
      tick;
      in_valid = 1'b1; in_sof = (i % 16 == 0); in_sample = din_q[i];
      if (i == 15) done_cyc = cyc;
      for (int g = 0; g < gap; g++) begin
        tick;
        in_valid = 1'b0; in_sof = 1'b1; in_sample = 16'hdead;
      end
    end
    tick;
    in_valid = 1'b0; in_sof = 1'b0; in_sample = 16'h0000;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_sample !== 16'h0000) begin errors++; $display("FAIL reset_sample got %h want 0000", out_sample); end
    checks++; if (out_index !== 4'd0) begin errors++; $display("FAIL reset_index got %0d want 0", out_index); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", out_last); end
    rst = 1'b0;
    repeat (3) tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", out_valid); end
  endtask

  task automatic test_ramp;
    clear_q; frame(0); run(0);
    for (int t = 0; t < 100 && got_s.size() < exp_q.size(); t++) tick;
    repeat (20) tick;
    checks++;
    if (got_s.size() != exp_q.size()) begin errors++; $display("FAIL ramp_count got %0d want %0d", got_s.size(), exp_q.size()); end
    checks++;
    if (got_c.size() == 0 || got_c[0] != done_cyc + 2) begin errors++; $display("FAIL ramp_latency got %0d want %0d", got_c.size() == 0 ? -1 : got_c[0], done_cyc + 2); end
    for (int k = 0; k < got_s.size() && k < exp_q.size(); k++) begin
      checks++;
      if ({got_s[k], got_i[k], got_l[k]} !== {exp_q[k], 4'(k % 16), (k % 16) == 15} || got_c[k] != got_c[0] + k) begin
        errors++;
        $display("FAIL ramp_y%0d got %0d idx %0d last %b cyc %0d want %0d idx %0d last %b cyc %0d", k, $signed(got_s[k]), got_i[k], got_l[k], got_c[k], $signed(exp_q[k]), k % 16, (k % 16) == 15, got_c[0] + k);
      end
    end
  endtask

  task automatic test_extremes;
    clear_q; frame(2); frame(1); run(0);
    for (int t = 0; t < 150 && got_s.size() < exp_q.size(); t++) tick;
    repeat (20) tick;
    checks++;
    if (got_s.size() != exp_q.size()) begin errors++; $display("FAIL ext_count got %0d want %0d", got_s.size(), exp_q.size()); end
    for (int k = 0; k < got_s.size() && k < exp_q.size(); k++) begin
      checks++;
      if ({got_s[k], got_i[k], got_l[k]} !== {exp_q[k], 4'(k % 16), (k % 16) == 15} || got_c[k] != got_c[0] + k) begin
        errors++;
        $display("FAIL ext_y%0d got %0d idx %0d last %b cyc %0d want %0d idx %0d last %b cyc %0d", k, $signed(got_s[k]), got_i[k], got_l[k], got_c[k], $signed(exp_q[k]), k % 16, (k % 16) == 15, got_c[0] + k);
      end
    end
  endtask

  task automatic test_back_to_back;
    clear_q; frame(0); frame(3); frame(1); run(0);
    for (int t = 0; t < 200 && got_s.size() < exp_q.size(); t++) tick;
    repeat (20) tick;
    checks++;
    if (got_s.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", got_s.size(), exp_q.size()); end
    for (int f = 1; f <= 3; f++) begin
      checks++;
      if (got_c.size() < 16 * f || got_c[16 * f - 1] != done_cyc + 1 + 16 * f) begin
        errors++;
        $display("FAIL b2b_last%0d got %0d want %0d", f, got_c.size() < 16 * f ? -1 : got_c[16 * f - 1], done_cyc + 1 + 16 * f);
      end
    end
    for (int k = 0; k < got_s.size() && k < exp_q.size(); k++) begin
      checks++;
      if ({got_s[k], got_i[k], got_l[k]} !== {exp_q[k], 4'(k % 16), (k % 16) == 15} || got_c[k] != got_c[0] + k) begin
        errors++;
        $display("FAIL b2b_y%0d got %0d idx %0d last %b cyc %0d want %0d idx %0d last %b cyc %0d", k, $signed(got_s[k]), got_i[k], got_l[k], got_c[k], $signed(exp_q[k]), k % 16, (k % 16) == 15, got_c[0] + k);
      end
    end
  endtask

  task automatic test_sparse;
    clear_q; frame(0); run(2);
    for (int t = 0; t < 100 && got_s.size() < exp_q.size(); t++) tick;
    repeat (20) tick;
    checks++;
    if (got_s.size() != exp_q.size()) begin errors++; $display("FAIL sparse_count got %0d want %0d", got_s.size(), exp_q.size()); end
    checks++;
    if (got_c.size() == 0 || got_c[0] != done_cyc + 2) begin errors++; $display("FAIL sparse_latency got %0d want %0d", got_c.size() == 0 ? -1 : got_c[0], done_cyc + 2); end
    for (int k = 0; k < got_s.size() && k < exp_q.size(); k++) begin
      checks++;
      if ({got_s[k], got_i[k], got_l[k]} !== {exp_q[k], 4'(k % 16), (k % 16) == 15} || got_c[k] != got_c[0] + k) begin
        errors++;
        $display("FAIL sparse_y%0d got %0d idx %0d last %b cyc %0d want %0d idx %0d last %b cyc %0d", k, $signed(got_s[k]), got_i[k], got_l[k], got_c[k], $signed(exp_q[k]), k % 16, (k % 16) == 15, got_c[0] + k);
      end
    end
  endtask

  task automatic test_resync;
    clear_q;
    for (int i = 0; i < 7; i++) begin
      tick;
      in_valid = 1'b1; in_sof = (i == 0); in_sample = 16'(500 + i);
    end
    frame(3); run(0);
    for (int t = 0; t < 100 && got_s.size() < exp_q.size(); t++) tick;
    repeat (30) tick;
    checks++;
    if (got_s.size() != exp_q.size()) begin errors++; $display("FAIL resync_count got %0d want %0d", got_s.size(), exp_q.size()); end
    for (int k = 0; k < got_s.size() && k < exp_q.size(); k++) begin
      checks++;
      if ({got_s[k], got_i[k], got_l[k]} !== {exp_q[k], 4'(k % 16), (k % 16) == 15} || got_c[k] != got_c[0] + k) begin
        errors++;
        $display("FAIL resync_y%0d got %0d idx %0d last %b cyc %0d want %0d idx %0d last %b cyc %0d", k, $signed(got_s[k]), got_i[k], got_l[k], got_c[k], $signed(exp_q[k]), k % 16, (k % 16) == 15, got_c[0] + k);
      end
    end
  endtask

  task automatic test_reset_mid_drain;
    clear_q; frame(0); run(0);
    for (int t = 0; t < 60 && got_s.size() < 6; t++) tick;
    checks++;
    if (got_s.size() != 6) begin errors++; $display("FAIL middrain_pre_count got %0d want 6", got_s.size()); end
    rst = 1'b1;
    tick;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL middrain_valid got %b want 0", out_valid); end
    rst = 1'b0;
    clear_q;
    for (int i = 0; i < 10; i++) begin
      tick;
      in_valid = 1'b1; in_sof = (i == 0); in_sample = 16'(200 + i);
    end
    tick;
    in_valid = 1'b0; in_sof = 1'b0;
    repeat (30) tick;
    checks++;
    if (got_s.size() != 0) begin errors++; $display("FAIL middrain_stale got %0d outputs want 0", got_s.size()); end
    clear_q; frame(0); run(0);
    for (int t = 0; t < 100 && got_s.size() < exp_q.size(); t++) tick;
    repeat (20) tick;
    checks++;
    if (got_s.size() != exp_q.size()) begin errors++; $display("FAIL middrain_count got %0d want %0d", got_s.size(), exp_q.size()); end
    checks++;
    if (got_c.size() == 0 || got_c[0] != done_cyc + 2) begin errors++; $display("FAIL middrain_latency got %0d want %0d", got_c.size() == 0 ? -1 : got_c[0], done_cyc + 2); end
    for (int k = 0; k < got_s.size() && k < exp_q.size(); k++) begin
      checks++;
      if ({got_s[k], got_i[k], got_l[k]} !== {exp_q[k], 4'(k % 16), (k % 16) == 15} || got_c[k] != got_c[0] + k) begin
        errors++;
        $display("FAIL middrain_y%0d got %0d idx %0d last %b cyc %0d want %0d idx %0d last %b cyc %0d", k, $signed(got_s[k]), got_i[k], got_l[k], got_c[k], $signed(exp_q[k]), k % 16, (k % 16) == 15, got_c[0] + k);
      end
    end
  endtask

  initial begin
    test_reset;
    test_ramp;
    test_extremes;
    test_back_to_back;
    test_sparse;
    test_resync;
    test_reset_mid_drain;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
